// File: rtl/ucsbece154b_fetch_queue_if.sv
// Instruction-memory request/response bus between the fetch queue and imem.
// The fetch queue is the master: it issues one request at a time and
// receives in-order read responses.
interface ucsbece154b_fetch_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_ready_i;
  logic            imem_rvalid_i;
  logic [31:0]     imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/ucsbece154b_fetch_queue.sv
// Decoupled instruction fetch queue.
// A three-state request FSM (IDLE/REQ/WAIT) keeps at most one imem request
// in flight and pushes returned words, tagged with their PC, into a
// DEPTH-entry circular FIFO that feeds the Fetch stage. An Execute-stage
// redirect flushes the FIFO and marks any in-flight response for discard.
// Optional feature: define UCSBECE154B_FETCH_BYPASS_EN to let a response
// arriving into an empty queue be presented combinationally the same cycle.
module ucsbece154b_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  ucsbece154b_fetch_queue_if.master imem,
  input  logic                      StallF_i,
  input  logic                      PCSrcE_i,
  input  logic [XLEN-1:0]           PCTargetE_i,
  output logic                      ValidF_o,
  output logic [XLEN-1:0]           PCF_o,
  output logic [31:0]               InstrF_o
);

  localparam int unsigned    PW      = $clog2(DEPTH);
  localparam int unsigned    CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]    NOP     = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            kill_q, kill_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            rsp;
  logic            rsp_live;
  logic            bypass;
  logic            bypass_take;
  logic            push;
  logic            pop;

  assign redirect = PCSrcE_i;
  // Redirect targets are forced onto a word boundary.
  assign target   = PCTargetE_i & ~XLEN'(3);

  // A response only counts while a request is outstanding; anything seen in
  // IDLE/REQ (e.g. a stale beat straddling reset) is ignored.
  assign rsp      = (state_q == WAIT) && imem.imem_rvalid_i;
  assign rsp_live = rsp && !kill_q && !redirect;

`ifdef UCSBECE154B_FETCH_BYPASS_EN
  assign bypass      = rsp_live && (count_q == '0);
  assign bypass_take = bypass && !StallF_i;
`else
  assign bypass      = 1'b0;
  assign bypass_take = 1'b0;
`endif

  // A bypassed word that the pipeline accepts never enters the FIFO.
  assign push = rsp_live && !bypass_take;
  assign pop  = (count_q != '0) && !StallF_i && !redirect;

  assign imem.imem_req_o  = (state_q == REQ);
  assign imem.imem_addr_o = req_addr_q;

  // Present the FIFO head, else the bypassed response, else a NOP bubble.
  always_comb begin
    ValidF_o = 1'b0;
    PCF_o    = fetch_pc_q;
    InstrF_o = NOP;
    if (count_q != '0) begin
      ValidF_o = 1'b1;
      PCF_o    = pc_mem[rd_ptr_q];
      InstrF_o = instr_mem[rd_ptr_q];
    end else if (bypass) begin
      ValidF_o = 1'b1;
      PCF_o    = req_addr_q;
      InstrF_o = imem.imem_rdata_i;
    end
  end

  // Occupancy: redirect flushes, simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q;
    if (redirect) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Request FSM next state, fetch PC, request address and kill flag.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    kill_d     = kill_q;

    unique case (state_q)
      IDLE: begin
        if (!redirect && (count_q < DEPTH_C)) begin
          state_d    = REQ;
          req_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (imem.imem_ready_i) begin
          state_d = WAIT;
          // A killed request was issued for the old path; the fetch PC
          // already points at the redirect target and must not advance.
          if (!kill_q) begin
            fetch_pc_d = fetch_pc_q + PC_INC;
          end
        end
      end
      WAIT: begin
        if (imem.imem_rvalid_i) begin
          kill_d = 1'b0;
          if (count_d < DEPTH_C) begin
            state_d    = REQ;
            req_addr_d = redirect ? target : fetch_pc_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Redirect overrides the sequential PC. A response landing in the same
    // cycle is dropped directly, so only a still-pending one needs kill.
    if (redirect) begin
      fetch_pc_d = target;
      if ((state_q == REQ) || ((state_q == WAIT) && !imem.imem_rvalid_i)) begin
        kill_d = 1'b1;
      end
    end
  end

  // FSM and fetch-control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      kill_q     <= kill_d;
    end
  end

  // FIFO occupancy and wrap-around pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  // FIFO storage: each entry is the request PC plus its returned word.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= req_addr_q;
      instr_mem[wr_ptr_q] <= imem.imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_ucsbece154b_fetch_queue.sv
// Directed bench for ucsbece154b_fetch_queue (default build, DEPTH=4).
// A small imem responder answers each accepted request one cycle later with
// word {16'hC0DE, addr[15:0]}, optionally held back to keep a response pending.
module tb_ucsbece154b_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        pcsrc;
  logic [31:0] target;
  logic        valid_f;
  logic [31:0] pc_f;
  logic [31:0] instr_f;

  logic        auto_rsp;
  logic        rsp_hold;
  logic        pend;
  logic [31:0] pend_a;
  int unsigned n_accept;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  ucsbece154b_fetch_queue_if #(.XLEN(32)) imem_bus ();

  ucsbece154b_fetch_queue #(
    .XLEN    (32),
    .DEPTH   (4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem       (imem_bus),
    .StallF_i   (stall),
    .PCSrcE_i   (pcsrc),
    .PCTargetE_i(target),
    .ValidF_o   (valid_f),
    .PCF_o      (pc_f),
    .InstrF_o   (instr_f)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample the handshake before the edge, update the responder
  // 1 time unit after it.
  task automatic tick();
    logic        acc;
    logic        consumed;
    logic [31:0] a;
    acc      = imem_bus.imem_req_o && imem_bus.imem_ready_i;
    consumed = imem_bus.imem_rvalid_i;
    a        = imem_bus.imem_addr_o;
    @(posedge clk);
    #1;
    if (consumed) pend = 1'b0;
    if (acc) begin
      pend   = 1'b1;
      pend_a = a;
      n_accept++;
    end
    if (auto_rsp) begin
      imem_bus.imem_rvalid_i = pend && !rsp_hold;
      imem_bus.imem_rdata_i  = pend ? {16'hC0DE, pend_a[15:0]} : 32'h0;
    end
  endtask

  task automatic do_reset(input string tag);
    reset    = 1'b0;
    stall    = 1'b0;
    pcsrc    = 1'b0;
    target   = 32'h0;
    auto_rsp = 1'b1;
    rsp_hold = 1'b0;
    pend     = 1'b0;
    n_accept = 0;
    imem_bus.imem_ready_i  = 1'b0;
    imem_bus.imem_rvalid_i = 1'b0;
    imem_bus.imem_rdata_i  = 32'h0;
    #1;
    chk({tag, "_rst_req"},   imem_bus.imem_req_o,  1'b0);
    chk({tag, "_rst_addr"},  imem_bus.imem_addr_o, 32'h0);
    chk({tag, "_rst_valid"}, valid_f,              1'b0);
    chk({tag, "_rst_pcf"},   pc_f,                 32'h0);
    chk({tag, "_rst_instr"}, instr_f,              32'h0000_0013);
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b1;
    stall    = 1'b0;
    pcsrc    = 1'b0;
    target   = 32'h0;
    auto_rsp = 1'b1;
    rsp_hold = 1'b0;
    pend     = 1'b0;
    pend_a   = 32'h0;
    n_accept = 0;
    imem_bus.imem_ready_i  = 1'b0;
    imem_bus.imem_rvalid_i = 1'b0;
    imem_bus.imem_rdata_i  = 32'h0;
    #2;

    // Streaming fetch: 0x0, 0x4, 0x8 every other cycle.
    do_reset("seq");
    imem_bus.imem_ready_i = 1'b1;
    tick();
    chk("seq_req1",  imem_bus.imem_req_o,  1'b1);
    chk("seq_addr1", imem_bus.imem_addr_o, 32'h0);
    tick();
    chk("seq_gap0",  valid_f, 1'b0);
    chk("seq_fpc",   pc_f,    32'h4);
    tick();
    chk("seq_v0",    valid_f, 1'b1);
    chk("seq_pc0",   pc_f,    32'h0);
    chk("seq_in0",   instr_f, 32'hC0DE_0000);
    chk("seq_req2",  imem_bus.imem_addr_o, 32'h4);
    tick();
    chk("seq_gap1",  valid_f, 1'b0);
    tick();
    chk("seq_v4",    valid_f, 1'b1);
    chk("seq_pc4",   pc_f,    32'h4);
    chk("seq_in4",   instr_f, 32'hC0DE_0004);
    tick();
    tick();
    chk("seq_v8",    valid_f, 1'b1);
    chk("seq_pc8",   pc_f,    32'h8);
    chk("seq_in8",   instr_f, 32'hC0DE_0008);

    // Stall fills the queue with exactly DEPTH requests, then drains in order.
    do_reset("full");
    imem_bus.imem_ready_i = 1'b1;
    stall = 1'b1;
    repeat (20) tick();
    chk("full_accepts", n_accept, 4);
    chk("full_req_off", imem_bus.imem_req_o, 1'b0);
    chk("full_head_v",  valid_f, 1'b1);
    chk("full_head_pc", pc_f,    32'h0);
    stall = 1'b0;
    tick();
    chk("full_pop1", pc_f, 32'h4);
    tick();
    chk("full_pop2",   pc_f, 32'h8);
    chk("full_resume", imem_bus.imem_req_o,  1'b1);
    chk("full_raddr",  imem_bus.imem_addr_o, 32'h10);
    tick();
    chk("full_pop3", pc_f, 32'hC);
    chk("full_v3",   valid_f, 1'b1);
    tick();
    chk("full_next_pc", pc_f,    32'h10);
    chk("full_next_in", instr_f, 32'hC0DE_0010);

    // Request held while memory is not ready.
    do_reset("hold");
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req",  imem_bus.imem_req_o,  1'b1);
      chk("hold_addr", imem_bus.imem_addr_o, 32'h0);
      chk("hold_fpc",  pc_f,                 32'h0);
    end
    imem_bus.imem_ready_i = 1'b1;
    tick();
    chk("hold_acc_fpc", pc_f, 32'h4);
    chk("hold_acc_req", imem_bus.imem_req_o, 1'b0);

    // Redirect in WAIT with the queue full: pending word is killed.
    do_reset("kill");
    imem_bus.imem_ready_i = 1'b1;
    stall = 1'b1;
    repeat (7) tick();
    rsp_hold = 1'b1;
    tick();
    chk("kill_pre_v",  valid_f, 1'b1);
    chk("kill_pre_pc", pc_f,    32'h0);
    chk("kill_pre_rq", imem_bus.imem_req_o, 1'b0);
    pcsrc  = 1'b1;
    target = 32'h100;
    tick();
    pcsrc  = 1'b0;
    chk("kill_flush_v", valid_f, 1'b0);
    chk("kill_fpc",     pc_f,    32'h100);
    rsp_hold = 1'b0;
    tick();
    chk("kill_wait_v",  valid_f, 1'b0);
    chk("kill_wait_rq", imem_bus.imem_req_o, 1'b0);
    tick();
    chk("kill_drop_v",  valid_f, 1'b0);
    chk("kill_new_rq",  imem_bus.imem_req_o,  1'b1);
    chk("kill_new_ad",  imem_bus.imem_addr_o, 32'h100);
    tick();
    tick();
    chk("kill_out_v",  valid_f, 1'b1);
    chk("kill_out_pc", pc_f,    32'h100);
    chk("kill_out_in", instr_f, 32'hC0DE_0100);

    // Redirect with a pop attempt and count=2; unaligned target.
    do_reset("rpop");
    imem_bus.imem_ready_i = 1'b1;
    stall = 1'b1;
    repeat (5) tick();
    chk("rpop_pre_pc", pc_f, 32'h0);
    stall  = 1'b0;
    pcsrc  = 1'b1;
    target = 32'h203;
    tick();
    pcsrc  = 1'b0;
    chk("rpop_v",   valid_f, 1'b0);
    chk("rpop_fpc", pc_f,    32'h200);
    chk("rpop_rq",  imem_bus.imem_req_o, 1'b0);
    tick();
    chk("rpop_nrq", imem_bus.imem_req_o,  1'b1);
    chk("rpop_nad", imem_bus.imem_addr_o, 32'h200);
    chk("rpop_v2",  valid_f, 1'b0);
    tick();
    chk("rpop_v3",  valid_f, 1'b0);
    tick();
    chk("rpop_ov",  valid_f, 1'b1);
    chk("rpop_opc", pc_f,    32'h200);
    chk("rpop_oin", instr_f, 32'hC0DE_0200);

    // Reset during WAIT, then a stray response after release.
    do_reset("mid");
    imem_bus.imem_ready_i = 1'b1;
    tick();
    tick();
    chk("mid_rv_pending", imem_bus.imem_rvalid_i, 1'b1);
    do_reset("mid2");
    auto_rsp = 1'b0;
    imem_bus.imem_rvalid_i = 1'b1;
    imem_bus.imem_rdata_i  = 32'hDEAD_BEEF;
    tick();
    imem_bus.imem_rvalid_i = 1'b0;
    chk("mid_v",   valid_f, 1'b0);
    chk("mid_rq",  imem_bus.imem_req_o,  1'b1);
    chk("mid_ad",  imem_bus.imem_addr_o, 32'h0);
    tick();
    chk("mid_v2",  valid_f, 1'b0);
    chk("mid_in2", instr_f, 32'h0000_0013);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_fetch_queue.md
UCSBECE154B_FETCH_QUEUE -- requirements
Module: ucsbece154b_fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, address/PC width.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, fetch PC after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 imem_req_o  output  1  instruction memory request valid.
REQ-007 imem_addr_o  output  XLEN  request address, word aligned.
REQ-008 imem_ready_i  input  1  memory accepts request this cycle.
REQ-009 imem_rvalid_i  input  1  read data valid (one response per accepted request, in order).
REQ-010 imem_rdata_i  input  32  instruction word.
REQ-011 StallF_i  input  1  pipeline cannot take an instruction this cycle.
REQ-012 PCSrcE_i  input  1  redirect (taken branch/jump) from Execute.
REQ-013 PCTargetE_i  input  XLEN  redirect target.
REQ-014 ValidF_o  output  1  PCF_o/InstrF_o hold a real instruction.
REQ-015 PCF_o  output  XLEN  PC of presented instruction; next fetch PC when ValidF_o=0.
REQ-016 InstrF_o  output  32  presented instruction; 32'h0000_0013 (NOP) when ValidF_o=0.

Function
REQ-017 Queue SHALL be a DEPTH-entry circular FIFO of {PC, instr}; wrap pointers modulo DEPTH, count 0..DEPTH.
REQ-018 FSM states IDLE, REQ, WAIT; at most one request outstanding.
REQ-019 IDLE->REQ when count+0 < DEPTH and no redirect; imem_req_o=1 only in REQ, imem_addr_o=latched req_addr.
REQ-020 In REQ, imem_req_o and imem_addr_o SHALL hold stable until imem_ready_i=1; then ->WAIT, fetch PC += 4.
REQ-021 WAIT->IDLE on imem_rvalid_i; entry {req_addr, imem_rdata_i} pushed unless kill=1 (REQ-025).
REQ-022 WAIT->REQ directly on imem_rvalid_i when space remains after the push (back-to-back fetch), req_addr = fetch PC.
REQ-023 Pop when ValidF_o=1 and StallF_i=0; push and pop in same cycle leave count unchanged.
REQ-024 Full (count+outstanding = DEPTH): no new request issued; resumes the cycle after a pop frees a slot.
REQ-025 PCSrcE_i=1: queue emptied (count=0), fetch PC=PCTargetE_i, no pop; if state REQ or WAIT, kill=1 so the in-flight response is discarded; FSM finishes that transaction, then issues from PCTargetE_i.
REQ-026 Redirect has priority over push and pop in the same cycle; ValidF_o=0 the cycle after a redirect unless bypass (REQ-032).
REQ-027 Redirect to a non-word-aligned target: bits [1:0] forced to 0.
REQ-028 Minimum latency imem_rvalid_i -> ValidF_o: 1 cycle (registered push).
REQ-029 kill SHALL clear when the killed response arrives; a second redirect while kill=1 keeps kill=1 and updates fetch PC only.

Reset
REQ-030 reset low, asynchronously: state IDLE, count=0, pointers=0, kill=0, fetch PC=RESET_PC; outputs imem_req_o=0, imem_addr_o=RESET_PC, ValidF_o=0, PCF_o=RESET_PC, InstrF_o=32'h0000_0013.
REQ-031 Reset mid-transaction SHALL abandon it; a response arriving after reset deassertion with no request issued SHALL be ignored.

Configuration
REQ-032 UCSBECE154B_FETCH_BYPASS_EN defined: when count=0, kill=0, imem_rvalid_i=1, no redirect, the response SHALL drive ValidF_o/PCF_o/InstrF_o combinationally same cycle, and if StallF_i=0 it is consumed without a push; undefined: no combinational path from imem_* to ValidF_o/PCF_o/InstrF_o, latency per REQ-028.

Verification
REQ-033 Reset, imem_ready_i=1, rvalid 1 cycle after accept, StallF_i=0 -> PCF_o sequence 0x0,0x4,0x8 with matching InstrF_o, no gaps beyond REQ-022 timing.
REQ-034 StallF_i=1 for 20 cycles, DEPTH=4 -> exactly 4 requests accepted, imem_req_o=0 afterwards, count=4; release -> 4 pops in order.
REQ-035 imem_ready_i=0 for 3 cycles in REQ -> imem_addr_o constant, fetch PC not incremented.
REQ-036 PCSrcE_i=1, PCTargetE_i=0x100 while WAIT -> in-flight word discarded, next ValidF_o=1 presents PCF_o=0x100, queue previously full emptied.
REQ-037 Redirect and pop same cycle with count=2 -> count=0, popped entry not reissued, next request address = target.
REQ-038 reset asserted during WAIT then rvalid pulse after release -> ValidF_o stays 0, first request address = RESET_PC.
